sync_fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of the team's synchronous FIFO. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, drives the FIFO `write`/`data_in` pair, and applies FIFO back-pressure through `fifo_full`. It sits directly in front of the FIFO's write side; the FIFO read side is untouched.

---
 rtl/sync_fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter
//   Round-robin arbiter that shares the single write port of a synchronous
//   FIFO between NUM_REQ valid/ready producers. A winner holds the port for
//   up to MAX_BURST words, or until it drops valid. Every grant is followed
//   by one idle arbitration cycle.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   req_valid_i    per-producer valid
//   req_data_i     per-producer word, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o    per-producer ready (one-hot or zero)
//   fifo_full_i    FIFO full flag
//   fifo_write_o   FIFO write strobe
//   fifo_data_o    FIFO write data (zero when idle)
//   grant_valid_o  a grant is active
//   grant_id_o     granted producer index (holds its value when idle)
//   burst_cnt_o    transfers completed in the current grant
module sync_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  parameter int GID_W      = $clog2(NUM_REQ)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic                             fifo_full_i,
  output logic                             fifo_write_o,
  output logic [DATA_WIDTH-1:0]            fifo_data_o,
  output logic                             grant_valid_o,
  output logic [GID_W-1:0]                 grant_id_o,
  output logic [3:0]                       burst_cnt_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [GID_W-1:0]       grant_id_q, grant_id_d;
  logic [GID_W-1:0]       last_id_q, last_id_d;
  logic [3:0]             burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
  logic                   win_found;
  logic [GID_W-1:0]       win_id;
  logic [GID_W-1:0]       cand;
  logic                   xfer;
  logic [3:0]             cnt_inc;

  assign data_arr = req_data_i;

  // Search starts just above the last winner, so the last winner is checked
  // last. Scanning k downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GID_W'((int'(last_id_q) + k) % NUM_REQ);
      if (req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign cnt_inc = burst_cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_id_d    = last_id_q;
    burst_cnt_d  = burst_cnt_q;
    req_ready_o  = '0;
    fifo_write_o = 1'b0;
    fifo_data_o  = '0;
    xfer         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = GRANT;
          grant_id_d  = win_id;
          last_id_d   = win_id;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        req_ready_o[grant_id_q] = !fifo_full_i;
        xfer                    = req_valid_i[grant_id_q] && !fifo_full_i;
        fifo_write_o            = xfer;
        fifo_data_o             = data_arr[grant_id_q];
        if (xfer) begin
          burst_cnt_d = cnt_inc;
          if (cnt_inc == 4'(MAX_BURST)) state_d = IDLE;
        end else if (!req_valid_i[grant_id_q]) begin
          // Producer ran dry: forfeit so others are not blocked.
          state_d = IDLE;
        end
        // Valid but FIFO full: hold grant and count with no timeout.
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_id_q   <= GID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_valid_o = (state_q == GRANT);
  assign grant_id_o    = grant_id_q;
  assign burst_cnt_o   = burst_cnt_q;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
module tb_sync_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_write;
  logic [DW-1:0]     fifo_data;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic [3:0]        burst_cnt;

  sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_full_i(fifo_full), .fifo_write_o(fifo_write),
    .fifo_data_o(fifo_data), .grant_valid_o(grant_valid), .grant_id_o(grant_id),
    .burst_cnt_o(burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [15:0] d; logic [3:0] c; } exp_t;
  exp_t        expq[$];
  logic [15:0] mem[$];
  int          wk[NR];
  logic [NR-1:0] vmask = '0;
  logic        full_force = 1'b0;
  logic        use_fifo = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [15:0] wval(input int p, input int k);
    return 16'(16'h0100 + p * 16'h1000 + k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic apply();
    req_valid = vmask;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = wval(i, wk[i]);
    fifo_full = full_force | (use_fifo && mem.size() >= DEPTH);
  endtask

  // One clock: capture handshakes mid-cycle, advance producers after the edge.
  task automatic cycle();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (use_fifo && fifo_write && !fifo_full) mem.push_back(fifo_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) wk[i]++;
    apply();
    #1;
  endtask

  task automatic step_chk(input string nm, input logic egv, input int eid);
    cycle();
    chk({nm, "_gv"}, 32'(grant_valid), 32'(egv));
    if (egv) chk({nm, "_gid"}, 32'(grant_id), 32'(eid));
  endtask

  task automatic push_burst(input int p, input int k0, input int n);
    for (int j = 0; j < n; j++) expq.push_back('{id: 2'(p), d: wval(p, k0 + j), c: 4'(j)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_cnt", 32'(burst_cnt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_write", 32'(fifo_write), 0);
    chk("rst_data", 32'(fifo_data), 0);
    vmask = '0; full_force = 1'b0;
    for (int i = 0; i < NR; i++) wk[i] = 0;
    apply();
    cycle();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: pops one expected word per observed FIFO write.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((fifo_write && fifo_full) || ($countones(req_ready) > 1)) begin
        bad++;
        $display("FAIL protocol write=%0b full=%0b ready=%b", fifo_write, fifo_full, req_ready);
      end
      if (fifo_write) begin
        exp_t e;
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write actual=%h id=%0d", fifo_data, grant_id);
        end else begin
          e = expq.pop_front();
          if (fifo_data !== e.d || grant_id !== e.id || burst_cnt !== e.c) begin
            bad++;
            $display("FAIL sb_write actual=%h/%0d/%0d expected=%h/%0d/%0d",
                     fifo_data, grant_id, burst_cnt, e.d, e.id, e.c);
          end
        end
      end
    end
  end

  initial begin
    #2;
    // Single producer: two full bursts with one idle cycle between.
    do_reset();
    push_burst(0, 0, 4); push_burst(0, 4, 4);
    vmask = 4'b0001; cycle();
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) vmask = '0;
      step_chk("single", (c % 5) != 0, 0);
    end
    chk("single_sb_empty", expq.size(), 0);

    // Round-robin over all four producers.
    do_reset();
    for (int g = 0; g < 5; g++) push_burst(g % 4, (g / 4) * 4, 4);
    vmask = 4'b1111; cycle();
    for (int c = 1; c <= 25; c++) begin
      if (c == 25) vmask = '0;
      step_chk("rr", ((c - 1) % 5) != 4, ((c - 1) / 5) % 4);
    end
    chk("rr_sb_empty", expq.size(), 0);

    // Early release: producer 2 drops out after two words.
    do_reset();
    push_burst(2, 0, 2); push_burst(3, 0, 4);
    vmask = 4'b1100; cycle();
    step_chk("early", 1, 2);
    step_chk("early", 1, 2);
    vmask = 4'b1000;
    step_chk("early_forfeit", 1, 2);
    step_chk("early_idle", 0, 0);
    for (int c = 0; c < 4; c++) step_chk("early_p3", 1, 3);
    vmask = '0;
    step_chk("early_end", 0, 0);
    chk("early_sb_empty", expq.size(), 0);

    // Full stall after the second write of a burst.
    do_reset();
    push_burst(1, 0, 4);
    vmask = 4'b0010; cycle();
    step_chk("stall_pre", 1, 1);
    step_chk("stall_pre", 1, 1);
    full_force = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step_chk("stall", 1, 1);
      chk("stall_write", 32'(fifo_write), 0);
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_cnt", 32'(burst_cnt), 2);
    end
    full_force = 1'b0;
    step_chk("stall_post", 1, 1);
    step_chk("stall_post", 1, 1);
    vmask = '0;
    step_chk("stall_end", 0, 0);
    chk("stall_sb_empty", expq.size(), 0);

    // Reset mid-burst, then producer 0 must win over producer 1.
    do_reset();
    push_burst(1, 0, 1);
    vmask = 4'b0010; cycle();
    step_chk("mid_first", 1, 1);
    cycle();
    do_reset();
    chk("mid_sb_empty", expq.size(), 0);
    wk[1] = 1;
    push_burst(0, 0, 4); push_burst(1, 1, 4);
    vmask = 4'b0011; apply(); #1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) vmask = '0;
      step_chk("mid_after", (c % 5) != 0, (c < 5) ? 0 : 1);
    end
    chk("mid_after_sb_empty", expq.size(), 0);

    // FIFO integration: stream until full, then check read-back order.
    do_reset();
    use_fifo = 1'b1;
    mem.delete();
    for (int g = 0; g < 8; g++) push_burst(g % 4, (g / 4) * 4, 4);
    vmask = 4'b1111; cycle();
    begin
      int n = 0;
      while (!fifo_full && n < 300) begin cycle(); n++; end
    end
    chk("fill_full", 32'(fifo_full), 1);
    repeat (3) cycle();
    vmask = '0;
    repeat (2) cycle();
    use_fifo = 1'b0;
    cycle();
    chk("fill_count", mem.size(), DEPTH);
    chk("fill_sb_empty", expq.size(), 0);
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 4; j++)
        if (g * 4 + j < mem.size())
          chk("readback", 32'(mem[g*4+j]), 32'(wval(g % 4, (g / 4) * 4 + j)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
